// File: rtl/if_pkg.sv
// Shared widths, constants and the fetch entry type for the instruction-fetch stage.
package if_pkg;
    localparam int XLEN = 64;
    localparam int ILEN = 32;
    localparam logic [XLEN-1:0] PC_STEP     = 64'd4;
    localparam logic [ILEN-1:0] BUBBLE_INST = 32'h0;

    typedef struct packed {
        logic [ILEN-1:0] inst;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries with flush; used as instruction buffer and in-flight PC queue.
module fetch_fifo
    import if_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  fetch_entry_t           push_data,
    input  logic                   pop,
    input  logic                   flush,
    output fetch_entry_t           head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty,
    output logic                   full
);
    localparam int PTR_W = $clog2(DEPTH);
    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [PTR_W:0]   cnt_t;

    fetch_entry_t mem_q [DEPTH];
    fetch_entry_t mem_d [DEPTH];
    ptr_t         rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    cnt_t         count_q, count_d;
    logic         do_push, do_pop;

    function automatic ptr_t next_ptr(input ptr_t p);
        return (p == ptr_t'(DEPTH - 1)) ? '0 : p + ptr_t'(1);
    endfunction

    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && !empty;
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = next_ptr(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_d = next_ptr(rd_ptr_q);
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + cnt_t'(1);
                2'b01:   count_d = count_q - cnt_t'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;
    assign empty = (count_q == '0);
    assign full  = (count_q == cnt_t'(DEPTH));
endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC, credit-limited imem requests, response buffer, redirect flush.
// Optional performance counters are enabled with `define FETCH_PERF_EN.
module if_fetch_stage
    import if_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC        = 64'h0,
    parameter int              FIFO_DEPTH      = 2,
    parameter int              MAX_OUTSTANDING = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            id_ready,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [ILEN-1:0] imem_rdata,
    output logic            if_valid,
    output logic [ILEN-1:0] if_inst,
    output logic [XLEN-1:0] if_pc
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]     perf_fetch_cnt,
    output logic [31:0]     perf_drop_cnt,
    output logic [31:0]     perf_stall_cnt
`endif
);
    localparam int OCW = $clog2(MAX_OUTSTANDING) + 1;
    localparam int FCW = $clog2(FIFO_DEPTH) + 1;
    typedef logic [OCW-1:0] ocnt_t;

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    ocnt_t           drop_cnt_q, drop_cnt_d;
    ocnt_t           outstanding;
    logic [FCW-1:0]  fifo_count;
    logic [31:0]     credit;
    fetch_entry_t    ibuf_head, ibuf_push_data, pcq_head, pcq_push_data;
    logic            ibuf_empty, ibuf_full, pcq_empty, pcq_full;
    logic            ibuf_push, ibuf_pop, grant, rsp;
    logic            fetch_unused;

    // Requests stop once in-flight plus buffered words would fill the buffer.
    always_comb begin
        credit   = 32'(outstanding) + 32'(fifo_count);
        imem_req = rst_n && !redirect_valid && (credit < 32'(FIFO_DEPTH)) && !pcq_full;
    end

    assign imem_addr      = fetch_pc_q;
    assign grant          = imem_req && imem_gnt;
    assign rsp            = imem_rvalid && !pcq_empty;
    assign ibuf_push      = rsp && !redirect_valid && (drop_cnt_q == '0);
    assign ibuf_pop       = if_valid && id_ready;
    assign pcq_push_data  = '{inst: BUBBLE_INST, pc: fetch_pc_q};
    assign ibuf_push_data = '{inst: imem_rdata, pc: pcq_head.pc};
    assign fetch_unused   = ^{pcq_head.inst, ibuf_full};

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        drop_cnt_d = drop_cnt_q;
        if (redirect_valid) begin
            fetch_pc_d = {redirect_pc[XLEN-1:2], 2'b00};
            drop_cnt_d = rsp ? outstanding - ocnt_t'(1) : outstanding;
        end else begin
            if (rsp && (drop_cnt_q != '0)) begin
                drop_cnt_d = drop_cnt_q - ocnt_t'(1);
            end
            if (grant) begin
                fetch_pc_d = fetch_pc_q + PC_STEP;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q <= RESET_PC;
            drop_cnt_q <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_ibuf (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (ibuf_push),
        .push_data (ibuf_push_data),
        .pop       (ibuf_pop),
        .flush     (redirect_valid),
        .head      (ibuf_head),
        .count     (fifo_count),
        .empty     (ibuf_empty),
        .full      (ibuf_full)
    );

    fetch_fifo #(.DEPTH(MAX_OUTSTANDING)) u_pcq (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (grant),
        .push_data (pcq_push_data),
        .pop       (rsp),
        .flush     (1'b0),
        .head      (pcq_head),
        .count     (outstanding),
        .empty     (pcq_empty),
        .full      (pcq_full)
    );

    assign if_valid = !ibuf_empty;
    assign if_inst  = if_valid ? ibuf_head.inst : BUBBLE_INST;
    assign if_pc    = if_valid ? ibuf_head.pc   : '0;

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch_q, perf_fetch_d;
    logic [31:0] perf_drop_q, perf_drop_d;
    logic [31:0] perf_stall_q, perf_stall_d;

    always_comb begin
        perf_fetch_d = perf_fetch_q;
        perf_drop_d  = perf_drop_q;
        perf_stall_d = perf_stall_q;
        if (ibuf_push) begin
            perf_fetch_d = perf_fetch_q + 32'd1;
        end
        if (rsp && !ibuf_push) begin
            perf_drop_d = perf_drop_q + 32'd1;
        end
        if (if_valid && !id_ready) begin
            perf_stall_d = perf_stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetch_q <= '0;
            perf_drop_q  <= '0;
            perf_stall_q <= '0;
        end else begin
            perf_fetch_q <= perf_fetch_d;
            perf_drop_q  <= perf_drop_d;
            perf_stall_q <= perf_stall_d;
        end
    end

    assign perf_fetch_cnt = perf_fetch_q;
    assign perf_drop_cnt  = perf_drop_q;
    assign perf_stall_cnt = perf_stall_q;
`endif
endmodule

// File: tb/tb_if_fetch_stage.sv
// Randomised self-checking bench for if_fetch_stage against a queue-based fetch model.
module tb_if_fetch_stage;
    import if_pkg::*;

    localparam logic [63:0] RESET_PC        = 64'hFFFF_FFFF_FFFF_FFF8;
    localparam int          FIFO_DEPTH      = 2;
    localparam int          MAX_OUTSTANDING = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = '0;
    logic        id_ready = 1'b0;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        if_valid;
    logic [31:0] if_inst;
    logic [63:0] if_pc;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch_cnt, perf_drop_cnt, perf_stall_cnt;
`endif

    if_fetch_stage #(
        .RESET_PC        (RESET_PC),
        .FIFO_DEPTH      (FIFO_DEPTH),
        .MAX_OUTSTANDING (MAX_OUTSTANDING)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_ready       (id_ready),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .if_valid       (if_valid),
        .if_inst        (if_inst),
        .if_pc          (if_pc)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_drop_cnt  (perf_drop_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: next fetch address, granted-but-unanswered addresses,
    // words owed to the drop counter and the visible instruction buffer.
    logic [63:0]  mFetchPc;
    logic [63:0]  mPend[$];
    int           mPendCyc[$];
    int           mDrop;
    fetch_entry_t mFifo[$];
    logic [31:0]  mPerfFetch, mPerfDrop, mPerfStall;

    int          cycle;
    int          checks;
    int          errors;
    int          mode;
    bit          forceRedir;
    logic [63:0] forcePc;

    function automatic logic [31:0] instOf(input logic [63:0] a);
        return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h1357_2468;
    endfunction

    function automatic bit expReq();
        return !redirect_valid
            && (mPend.size() + mFifo.size() < FIFO_DEPTH)
            && (mPend.size() < MAX_OUTSTANDING);
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed %h, expected %h (cycle %0d)", tag, observed, expected, cycle);
        end
    endtask

    // Memory responds in order, never earlier than the cycle after the grant.
    task automatic applyStimulus();
        bit canRsp;
        canRsp = 1'b0;
        if (mPend.size() > 0) begin
            canRsp = (mPendCyc[0] < cycle);
        end
        case (mode)
            0: begin
                imem_gnt = 1'b1; id_ready = 1'b1; imem_rvalid = canRsp; redirect_valid = 1'b0;
            end
            1: begin
                imem_gnt = 1'b1; id_ready = 1'b0; imem_rvalid = canRsp; redirect_valid = 1'b0;
            end
            3: begin
                imem_gnt = 1'b1; id_ready = 1'b1; imem_rvalid = 1'b0; redirect_valid = 1'b0;
            end
            default: begin
                imem_gnt       = ($urandom_range(0, 3) != 0);
                id_ready       = ($urandom_range(0, 3) != 0);
                redirect_valid = ($urandom_range(0, 15) == 0);
                redirect_pc    = {$urandom, $urandom};
                if (mPend.size() > 0) begin
                    imem_rvalid = canRsp && ($urandom_range(0, 2) != 0);
                end else begin
                    imem_rvalid = ($urandom_range(0, 7) == 0);
                end
            end
        endcase
        if (forceRedir) begin
            redirect_valid = 1'b1;
            redirect_pc    = forcePc;
        end
        imem_rdata = (mPend.size() > 0) ? instOf(mPend[0]) : $urandom;
    endtask

    task automatic modelStep();
        bit          grant;
        logic [63:0] a;
        grant = expReq() && imem_gnt;
        if ((mFifo.size() > 0) && !id_ready) mPerfStall++;
        if ((mFifo.size() > 0) && id_ready && !redirect_valid) void'(mFifo.pop_front());
        if (imem_rvalid && (mPend.size() > 0)) begin
            a = mPend.pop_front();
            void'(mPendCyc.pop_front());
            if (redirect_valid || (mDrop > 0)) begin
                mPerfDrop++;
                if (!redirect_valid) mDrop--;
            end else begin
                mFifo.push_back('{inst: instOf(a), pc: a});
                mPerfFetch++;
            end
        end
        if (redirect_valid) begin
            mFifo.delete();
            mDrop    = mPend.size();
            mFetchPc = {redirect_pc[63:2], 2'b00};
        end else if (grant) begin
            mPend.push_back(mFetchPc);
            mPendCyc.push_back(cycle);
            mFetchPc = mFetchPc + 64'd4;
        end
    endtask

    task automatic stepCycle();
        fetch_entry_t h;
        @(negedge clk);
        applyStimulus();
        #1;
        h = (mFifo.size() > 0) ? mFifo[0] : '0;
        checkOutput("imem_req",  64'(imem_req), 64'(expReq()));
        checkOutput("imem_addr", imem_addr, mFetchPc);
        checkOutput("if_valid",  64'(if_valid), 64'(mFifo.size() > 0));
        checkOutput("if_inst",   64'(if_inst), 64'(h.inst));
        checkOutput("if_pc",     if_pc, h.pc);
`ifdef FETCH_PERF_EN
        checkOutput("perf_fetch", 64'(perf_fetch_cnt), 64'(mPerfFetch));
        checkOutput("perf_drop",  64'(perf_drop_cnt),  64'(mPerfDrop));
        checkOutput("perf_stall", 64'(perf_stall_cnt), 64'(mPerfStall));
`endif
        modelStep();
        cycle++;
    endtask

    // Reset is applied away from the clock edge and its effect checked at once.
    task automatic doReset();
        @(negedge clk);
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        imem_gnt       = 1'b0;
        imem_rvalid    = 1'b0;
        id_ready       = 1'b1;
        #1;
        checkOutput("rst_imem_req", 64'(imem_req), 64'd0);
        checkOutput("rst_if_valid", 64'(if_valid), 64'd0);
        checkOutput("rst_if_inst",  64'(if_inst), 64'd0);
        checkOutput("rst_if_pc",    if_pc, 64'd0);
        checkOutput("rst_imem_addr", imem_addr, RESET_PC);
        mPend.delete();
        mPendCyc.delete();
        mFifo.delete();
        mDrop      = 0;
        mFetchPc   = RESET_PC;
        mPerfFetch = '0;
        mPerfDrop  = '0;
        mPerfStall = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic redirectTo(input logic [63:0] target);
        forcePc    = target;
        forceRedir = 1'b1;
        stepCycle();
        forceRedir = 1'b0;
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        cycle      = 0;
        mode       = 0;
        forceRedir = 1'b0;
        forcePc    = '0;
        doReset();

        mode = 0; repeat (20) stepCycle();
        mode = 1; repeat (10) stepCycle();
        mode = 0; repeat (10) stepCycle();

        mode = 3; repeat (4) stepCycle();
        redirectTo(64'h1000);
        mode = 0; repeat (10) stepCycle();

        redirectTo(64'h2003);
        repeat (10) stepCycle();

        mode = 2; repeat (600) stepCycle();

        mode = 1; repeat (6) stepCycle();
        mode = 3; repeat (1) stepCycle();
        doReset();
        mode = 0; repeat (10) stepCycle();

        redirectTo(64'hFFFF_FFFF_FFFF_FFF5);
        repeat (10) stepCycle();

        mode = 2; repeat (600) stepCycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
